// File: rtl/rx_report_arb.sv
// Round-robin arbiter that moves whole fixed-length reports from PHY_NUM
// receive channels into one shared RX report FIFO. Reports from masked channels are popped and discarded.
//
// state | meaning
// ARB   | scan requests from ptr+1, grant when the report can be taken or dropped
// XFER  | stream RX_DATA_LEN words of the granted channel into the FIFO
// DRAIN | pop RX_DATA_LEN words of a masked channel and discard them
module rx_report_arb #(
    parameter int PHY_NUM       = 32,
    parameter int RX_DATA_LEN   = 8,
    parameter int RX_FIFO_DEPTH = 512,
    parameter int CNT_W         = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_flush,
    input  logic [PHY_NUM-1:0]     reg_mask,
    input  logic [PHY_NUM-1:0]     ch_req,
    input  logic [32*PHY_NUM-1:0]  ch_dat,
    output logic [PHY_NUM-1:0]     ch_rd,
    input  logic [CNT_W-1:0]       rx_data_count,
    output logic                   rx_vld,
    output logic [31:0]            rx_dat,
    output logic [PHY_NUM-1:0]     gnt,
    output logic [15:0]            drop_cnt,
    output logic                   arb_busy
);

    localparam int IDX_W = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;
    localparam int LEN_W = $clog2(RX_DATA_LEN + 1);
    localparam int SUM_W = CNT_W + 2;

    localparam logic [SUM_W-1:0] NEED_WORDS = SUM_W'(2 * RX_DATA_LEN);
    localparam logic [SUM_W-1:0] FIFO_WORDS = SUM_W'(RX_FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LAST_WORD  = LEN_W'(RX_DATA_LEN - 1);
    localparam logic [IDX_W-1:0] PTR_INIT   = IDX_W'(PHY_NUM - 1);
    localparam logic [PHY_NUM-1:0] ONE_HOT0 = PHY_NUM'(1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [LEN_W-1:0] cnt;

    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] scan;
    logic             cand_vld;
    logic             space_ok;
    logic [SUM_W-1:0] occ_need;
    logic [31:0]      ch_word [PHY_NUM];

    // Headroom of two reports so a grant never races an in-flight report.
    assign occ_need = SUM_W'(rx_data_count) + NEED_WORDS;
    assign space_ok = (occ_need <= FIFO_WORDS);

    always_comb begin
        for (int i = 0; i < PHY_NUM; i++) begin
            ch_word[i] = ch_dat[32*i +: 32];
        end
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        scan     = '0;
        for (int k = 1; k <= PHY_NUM; k++) begin
            scan = IDX_W'((int'(ptr) + k) % PHY_NUM);
            if (!cand_vld && ch_req[scan]) begin
                cand_vld = 1'b1;
                cand_idx = scan;
            end
        end
    end

    assign ch_rd = (state == ARB) ? '0 : gnt;

    always_ff @(posedge clk) begin
        if (rst || reg_flush) begin
            state    <= ARB;
            ptr      <= PTR_INIT;
            gnt_idx  <= '0;
            gnt      <= '0;
            cnt      <= '0;
            arb_busy <= 1'b0;
            rx_vld   <= 1'b0;
            rx_dat   <= '0;
            drop_cnt <= '0;
        end else begin
            rx_vld <= (state == XFER);
            if (state == XFER) begin
                rx_dat <= ch_word[gnt_idx];
            end
            case (state)
                ARB: begin
                    // A blocked unmasked head keeps priority; no skipping ahead.
                    if (cand_vld && (!reg_mask[cand_idx] || space_ok)) begin
                        state    <= reg_mask[cand_idx] ? XFER : DRAIN;
                        gnt      <= ONE_HOT0 << cand_idx;
                        gnt_idx  <= cand_idx;
                        cnt      <= '0;
                        arb_busy <= 1'b1;
                    end
                end
                XFER, DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_WORD) begin
                        state    <= ARB;
                        gnt      <= '0;
                        arb_busy <= 1'b0;
                        ptr      <= gnt_idx;
                        if (state == DRAIN && drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_report_arb.sv
// Bench for rx_report_arb: directed scenarios then random traffic, all checked
// each cycle against a report-level reference model.
module tb_rx_report_arb;

    localparam int N     = 32;
    localparam int LEN   = 8;
    localparam int DEPTH = 512;
    localparam int CW    = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            reg_flush = 1'b0;
    logic [N-1:0]    reg_mask = '1;
    logic [N-1:0]    ch_req = '0;
    logic [32*N-1:0] ch_dat;
    logic [N-1:0]    ch_rd;
    logic [CW-1:0]   rx_data_count = '0;
    logic            rx_vld;
    logic [31:0]     rx_dat;
    logic [N-1:0]    gnt;
    logic [15:0]     drop_cnt;
    logic            arb_busy;

    always #5 clk = ~clk;

    rx_report_arb #(.PHY_NUM(N), .RX_DATA_LEN(LEN), .RX_FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_mask(reg_mask),
        .ch_req(ch_req), .ch_dat(ch_dat), .ch_rd(ch_rd), .rx_data_count(rx_data_count),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .gnt(gnt), .drop_cnt(drop_cnt), .arb_busy(arb_busy)
    );

    // Channel sources: head word = {channel, 8'h00, pop count}.
    logic [15:0] seq [N] = '{default: 16'd0};
    always_comb begin
        for (int i = 0; i < N; i++) ch_dat[32*i +: 32] = {8'(i), 8'h00, seq[i]};
    end
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) seq[i] <= 16'd0;
            else if (ch_rd[i]) seq[i] <= seq[i] + 16'd1;
        end
    end

    // Reference model: tracks which report is in flight and how many words remain.
    bit          m_act = 0, m_drain = 0, e_vld = 0;
    int          m_ch = 0, m_left = 0, m_ptr = N - 1, m_drop = 0;
    logic [31:0] e_dat = '0;

    always @(posedge clk) begin
        bit          nv;
        logic [31:0] nd;
        int          c;
        nv = 0;
        nd = e_dat;
        if (rst || reg_flush) begin
            m_act = 0; m_ptr = N - 1; m_drop = 0; nd = '0;
        end else if (m_act) begin
            if (!m_drain) begin nv = 1; nd = ch_dat[32*m_ch +: 32]; end
            m_left--;
            if (m_left == 0) begin
                m_act = 0;
                m_ptr = m_ch;
                if (m_drain && m_drop < 65535) m_drop++;
            end
        end else begin
            c = -1;
            for (int k = 1; k <= N; k++) begin
                if (c < 0 && ch_req[(m_ptr + k) % N]) c = (m_ptr + k) % N;
            end
            if (c >= 0) begin
                if (!reg_mask[c]) begin
                    m_act = 1; m_drain = 1; m_ch = c; m_left = LEN;
                end else if (int'(rx_data_count) + 2*LEN <= DEPTH) begin
                    m_act = 1; m_drain = 0; m_ch = c; m_left = LEN;
                end
            end
        end
        e_vld = nv;
        e_dat = nd;
    end

    int n_pass = 0, n_fail = 0, n_tot = 0;
    int vld_seen = 0;
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] gq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] eg;
        eg = m_act ? (32'h1 << m_ch) : 32'h0;
        chk("gnt", gnt, eg);
        chk("ch_rd", ch_rd, eg);
        chk("arb_busy", {31'b0, arb_busy}, {31'b0, m_act});
        chk("rx_vld", {31'b0, rx_vld}, {31'b0, e_vld});
        chk("rx_dat", rx_dat, e_dat);
        chk("drop_cnt", {16'b0, drop_cnt}, 32'(m_drop));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
            if (rx_vld) vld_seen++;
            if (gnt != '0 && prev_gnt == '0) gq.push_back(gnt);
            prev_gnt = gnt;
        end
    endtask

    initial begin
        logic [N-1:0] exp_order [5];

        // Reset
        rst = 1; step(3);
        chk("reset_gnt", gnt, 32'h0);
        chk("reset_drop", {16'b0, drop_cnt}, 32'h0);
        rst = 0;

        // Single report from channel 0
        vld_seen = 0;
        ch_req = 32'h1; step(1);
        chk("first_gnt", gnt, 32'h1);
        ch_req = '0; step(11);
        chk("single_len", 32'(vld_seen), 32'(LEN));

        // Round-robin order from reset pointer
        rst = 1; step(1); rst = 0;
        gq.delete();
        ch_req = 32'h8000_0005; step(50);
        ch_req = '0; step(10);
        exp_order = '{32'h1, 32'h4, 32'h8000_0000, 32'h1, 32'h4};
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk("rr_order", gq[i], exp_order[i]);
            else chk("rr_order_missing", 32'h0, exp_order[i]);
        end

        // FIFO space boundary
        rx_data_count = 10'd497;
        ch_req = 32'h8; step(6);
        chk("space_hold", gnt, 32'h0);
        rx_data_count = 10'd496; step(1);
        chk("space_gnt", gnt, 32'h8);
        ch_req = '0; step(10);
        rx_data_count = '0;

        // Masked channel is drained
        vld_seen = 0;
        reg_mask = ~32'h20; ch_req = 32'h20; step(1);
        ch_req = '0; step(10);
        chk("drain_vld", 32'(vld_seen), 32'h0);
        chk("drain_cnt", {16'b0, drop_cnt}, 32'h1);
        reg_mask = '1;

        // Flush on the 4th transfer word
        ch_req = 32'h200; step(4);
        reg_flush = 1; ch_req = 32'h210; step(1);
        reg_flush = 0;
        chk("flush_gnt", gnt, 32'h0);
        step(1);
        chk("flush_next", gnt, 32'h10);
        ch_req = '0; step(10);

        // Mask cleared mid-transfer
        vld_seen = 0;
        ch_req = 32'h40; step(3);
        reg_mask = ~32'h40; step(17);
        chk("midmask_len", 32'(vld_seen), 32'(LEN));
        ch_req = '0; step(10);
        reg_mask = '1;

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) ch_req = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 31) == 0) reg_mask = ~($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) rx_data_count = CW'($urandom_range(400, 520));
            reg_flush = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst = 0; reg_flush = 0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rx_report_arb.md
Name: rx_report_arb

Overview:
- Shares the single RX report FIFO between up to PHY_NUM receive-PHY channels, each holding complete fixed-length reports.
- Picks one requesting channel in round-robin order and streams exactly RX_DATA_LEN words from it into the FIFO write port.
- Holds off new grants when the FIFO cannot take a whole report.
- Discards reports from masked channels so a masked, chattering PHY cannot stall the link.

Parameters:
- PHY_NUM, 32: number of requesting channels.
- RX_DATA_LEN, 8: words per report.
- RX_FIFO_DEPTH, 512: FIFO capacity in words.
- CNT_W, 10: width of the FIFO data_count input.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- reg_flush  in  1  software flush. Synchronous; same effect as rst.
- reg_mask  in  PHY_NUM  1 = channel enabled; 0 = channel's reports are discarded.
- ch_req  in  PHY_NUM  channel holds at least one complete report.
- ch_dat  in  32*PHY_NUM  per-channel head word, first-word-fall-through. Channel i occupies bits [32i+31:32i].
- ch_rd  out  PHY_NUM  per-channel pop strobe. One-hot or zero.
- rx_data_count  in  CNT_W  current FIFO occupancy.
- rx_vld  out  1  FIFO write enable.
- rx_dat  out  32  FIFO write data.
- gnt  out  PHY_NUM  registered one-hot grant. Zero when idle.
- drop_cnt  out  16  count of discarded reports. Saturates at 16'hFFFF.
- arb_busy  out  1  high while a transfer or drain is in progress.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst and reg_flush are synchronous and active-high; both act identically.
- Reset values:
  - gnt = 0, ch_rd = 0, rx_vld = 0, rx_dat = 0, drop_cnt = 0, arb_busy = 0.
  - Round-robin pointer ptr = PHY_NUM-1, so channel 0 has first priority.
  - Word counter = 0. State = ARB.
- States:
  - ARB: evaluates requests every cycle.
  - XFER: copies one report into the FIFO.
  - DRAIN: pops one report from a masked channel and discards it.
- Space check:
  - space_ok = (rx_data_count + 2*RX_DATA_LEN) <= RX_FIFO_DEPTH.
  - Computed at CNT_W+2 bits; no overflow is permitted.
- ARB:
  - Candidate = first i with ch_req[i]=1, searching ptr+1, ptr+2, ... modulo PHY_NUM.
  - Candidate masked: go to DRAIN. Space is not required.
  - Candidate unmasked and space_ok: go to XFER.
  - Candidate unmasked and !space_ok: stay in ARB. ptr unchanged, gnt stays 0, no skip to a later channel. The head channel keeps priority until space frees.
  - On either transition: gnt <= onehot(candidate), counter <= 0, arb_busy <= 1.
- XFER and DRAIN (per cycle):
  - ch_rd = gnt. This is combinational from registered gnt and state.
  - Counter increments each cycle.
  - When counter == RX_DATA_LEN-1: return to ARB, gnt <= 0, arb_busy <= 0, ptr <= granted index.
  - DRAIN additionally: drop_cnt increments (saturating) on its final word.
- Write port:
  - rx_vld and rx_dat are registered: rx_vld(t+1) = XFER(t); rx_dat(t+1) = ch_dat[gnt](t).
  - rx_vld is never asserted for DRAIN.
  - rx_dat holds its last value when rx_vld = 0.
- Latency and throughput:
  - ch_req seen in ARB at cycle N: gnt and first ch_rd at N+1, first rx_vld at N+2.
  - Exactly RX_DATA_LEN contiguous rx_vld cycles per report.
  - One ARB cycle between consecutive grants, so maximum throughput is RX_DATA_LEN words per RX_DATA_LEN+1 cycles.
- Channel contract:
  - ch_req, once sampled high, guarantees RX_DATA_LEN words are available.
  - ch_req falling mid-transfer is ignored; the report always completes.
  - reg_mask changing mid-transfer does not alter the current transfer. It applies at the next ARB.
- Flush or reset mid-XFER:
  - Transfer aborts in the same clock edge.
  - ch_rd drops the following cycle; rx_vld is 0 the following cycle.
  - No partial-report completion. FIFO and channels are flushed externally by the same signal.
- Simultaneous events:
  - rst/reg_flush take precedence over any state transition and over the drop_cnt increment.

Test Plan:
- Reset, then ch_req=32'h1, mask all 1s, rx_data_count=0, ch_dat[0] counting 0..7 → gnt=1 at N+1; rx_vld high N+2..N+9 with rx_dat 0..7; ch_rd[0] high 8 cycles; gnt=0 at N+9.
- ch_req = 32'h8000_0005 held continuously, mask all 1s → grant order 0, 2, 31, 0, 2, …; exactly one idle ARB cycle between grants.
- rx_data_count = 497 (space_ok false), ch_req[3]=1 → no grant, no ch_rd. Drop count to 496 → gnt[3] next cycle.
- reg_mask[5]=0, ch_req[5]=1 → ch_rd[5] high 8 cycles, rx_vld stays 0, drop_cnt 0→1. Preloaded drop_cnt=16'hFFFF stays 16'hFFFF.
- reg_flush pulsed on the 4th XFER word → next cycle gnt=0, ch_rd=0, rx_vld=0, arb_busy=0, ptr=31. Next grant goes to the lowest requesting channel.
- Mask bit cleared mid-XFER on the granted channel → current report still writes all 8 words; next report from that channel is drained.
